// File: rtl/mem_pkg.sv
// Shared definitions for the byte-serial memory bridge and the decoder that
// drives it: size encodings, bridge state type and request helper functions.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'h0;
    localparam logic [1:0] SZ_HALF = 2'h1;
    localparam logic [1:0] SZ_WORD = 2'h2;
    localparam logic [1:0] SZ_RSVD = 2'h3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        FINISH = 2'd2
    } state_e;

    // Number of byte transfers for a size code; 0 for the reserved code.
    function automatic logic [2:0] byte_count(input logic [1:0] size);
        logic [2:0] n;
        case (size)
            SZ_BYTE: n = 3'd1;
            SZ_HALF: n = 3'd2;
            SZ_WORD: n = 3'd4;
            default: n = 3'd0;
        endcase
        return n;
    endfunction

    // A request is rejected for the reserved size or a misaligned address.
    function automatic logic req_illegal(input logic [1:0] size, input logic [1:0] adr_lo);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = adr_lo[0];
            SZ_WORD: bad = (adr_lo != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/load_extend.sv
// Combinational load formatter: takes the little-endian assembled bytes and
// produces the zero- or sign-extended 32-bit load value for the access size.
module load_extend
    import mem_pkg::*;
(
    input  logic [3:0][7:0] bytes_in,
    input  logic [1:0]      size,
    input  logic            load_signed,
    output logic [31:0]     value
);

    // Select width and extension from the size code; word passes straight through.
    always_comb begin
        value = {bytes_in[3], bytes_in[2], bytes_in[1], bytes_in[0]};
        case (size)
            SZ_BYTE: value = {{24{load_signed & bytes_in[0][7]}}, bytes_in[0]};
            SZ_HALF: value = {{16{load_signed & bytes_in[1][7]}}, bytes_in[1], bytes_in[0]};
            default: value = {bytes_in[3], bytes_in[2], bytes_in[1], bytes_in[0]};
        endcase
    end

endmodule

// File: rtl/mem_byte_bridge.sv
// Responder for the core's memory request: runs each load/store as a burst of
// byte transfers on an 8-bit req/ack bus, keeping busy high so the core stalls.
// Bus handshake: bus_req rises on the edge after an accepted start and stays
// high for every byte of the request; a byte completes on any edge where
// bus_ack is high while bus_req is high, and address/data move to the next
// byte only on that edge. bus_ack with bus_req low is ignored.
module mem_byte_bridge
    import mem_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              MemW,
    input  logic [2:0]        memSelect,
    input  logic [ADDR_W-1:0] Adr,
    input  logic [31:0]       WriteData,
    output logic [31:0]       ReadData,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              bus_req,
    output logic              bus_we,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    input  logic [7:0]        bus_rdata,
    input  logic              bus_ack
);

    // Wait counter only has to reach TIMEOUT-1; it stays at zero when disabled.
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
    localparam logic [CW-1:0] WAIT_LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

    state_e            state_q, state_d;
    logic              we_q, we_d;
    logic [1:0]        size_q, size_d;
    logic              signed_q, signed_d;
    logic [ADDR_W-1:0] adr_q, adr_d;
    logic [3:0][7:0]   wdata_q, wdata_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [1:0]        idx_q, idx_d;
    logic [CW-1:0]     wait_q, wait_d;
    logic [3:0][7:0]   asm_q, asm_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic              req_q, req_d;
    logic              bwe_q, bwe_d;
    logic [ADDR_W-1:0] baddr_q, baddr_d;
    logic [7:0]        bwdata_q, bwdata_d;

    logic [3:0][7:0]   asm_next;
    logic [1:0]        idx_next;
    logic              last_byte;
    logic [31:0]       load_value;

    // Final load value includes the byte arriving on the completing edge.
    load_extend u_load_extend (
        .bytes_in    (asm_next),
        .size        (size_q),
        .load_signed (signed_q),
        .value       (load_value)
    );

    // Next-state and next-output computation for the transfer sequencer.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        adr_d    = adr_q;
        wdata_d  = wdata_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        wait_d   = wait_q;
        asm_d    = asm_q;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        req_d    = req_q;
        bwe_d    = bwe_q;
        baddr_d  = baddr_q;
        bwdata_d = bwdata_q;

        asm_next           = asm_q;
        asm_next[idx_q]    = bus_rdata;
        idx_next           = idx_q + 2'd1;
        last_byte          = (({1'b0, idx_q} + 3'd1) == cnt_q);

        case (state_q)
            IDLE: begin
                if (start) begin
                    we_d     = MemW;
                    size_d   = memSelect[1:0];
                    signed_d = memSelect[2];
                    adr_d    = Adr;
                    wdata_d  = MemW ? WriteData : 32'h0;
                    cnt_d    = byte_count(memSelect[1:0]);
                    idx_d    = 2'd0;
                    wait_d   = '0;
                    asm_d    = '0;
                    if (req_illegal(memSelect[1:0], Adr[1:0])) begin
                        state_d = FINISH;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                    end else begin
                        state_d  = ACCESS;
                        busy_d   = 1'b1;
                        req_d    = 1'b1;
                        bwe_d    = MemW;
                        baddr_d  = Adr;
                        bwdata_d = MemW ? WriteData[7:0] : 8'h0;
                    end
                end
            end
            ACCESS: begin
                if (bus_ack) begin
                    asm_d  = asm_next;
                    wait_d = '0;
                    if (last_byte) begin
                        state_d  = FINISH;
                        done_d   = 1'b1;
                        busy_d   = 1'b0;
                        req_d    = 1'b0;
                        bwe_d    = 1'b0;
                        baddr_d  = '0;
                        bwdata_d = 8'h0;
                        if (!we_q) begin
                            rdata_d = load_value;
                        end
                    end else begin
                        idx_d    = idx_next;
                        baddr_d  = adr_q + ADDR_W'(idx_next);
                        bwdata_d = we_q ? wdata_q[idx_next] : 8'h0;
                    end
                end else if (TIMEOUT != 0 && wait_q == WAIT_LAST) begin
                    state_d  = FINISH;
                    done_d   = 1'b1;
                    err_d    = 1'b1;
                    busy_d   = 1'b0;
                    req_d    = 1'b0;
                    bwe_d    = 1'b0;
                    baddr_d  = '0;
                    bwdata_d = 8'h0;
                end else if (TIMEOUT != 0) begin
                    wait_d = wait_q + CW'(1);
                end
            end
            FINISH: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Register state, captured request and all outputs; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            size_q   <= 2'h0;
            signed_q <= 1'b0;
            adr_q    <= '0;
            wdata_q  <= '0;
            cnt_q    <= 3'd0;
            idx_q    <= 2'd0;
            wait_q   <= '0;
            asm_q    <= '0;
            rdata_q  <= 32'h0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            req_q    <= 1'b0;
            bwe_q    <= 1'b0;
            baddr_q  <= '0;
            bwdata_q <= 8'h0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            adr_q    <= adr_d;
            wdata_q  <= wdata_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            wait_q   <= wait_d;
            asm_q    <= asm_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            req_q    <= req_d;
            bwe_q    <= bwe_d;
            baddr_q  <= baddr_d;
            bwdata_q <= bwdata_d;
        end
    end

    assign ReadData  = rdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign bus_req   = req_q;
    assign bus_we    = bwe_q;
    assign bus_addr  = baddr_q;
    assign bus_wdata = bwdata_q;

endmodule

// File: tb/tb_mem_byte_bridge.sv
// Bench for mem_byte_bridge: a transaction-level model builds a per-cycle
// stimulus schedule and the matching expected outputs; a driver replays the
// stimulus and a comparator checks the DUT every cycle.
module tb_mem_byte_bridge;

    localparam int T = 4;

    logic        clk;
    logic        reset;
    logic        start;
    logic        MemW;
    logic [2:0]  memSelect;
    logic [31:0] Adr;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        busy;
    logic        done;
    logic        err;
    logic        bus_req;
    logic        bus_we;
    logic [31:0] bus_addr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata;
    logic        bus_ack;

    typedef struct packed {
        logic        rst;
        logic        start;
        logic        memw;
        logic [2:0]  sel;
        logic [31:0] adr;
        logic [31:0] wdata;
        logic        ack;
        logic [7:0]  rdata;
    } stim_t;

    typedef struct packed {
        logic        chk;
        logic        full;
        logic        chk_wd;
        logic        busy;
        logic        done;
        logic        err;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [7:0]  wdata;
        logic [31:0] rdata;
    } out_t;

    localparam int W = $bits(out_t);

    logic [W-1:0] exp_q[$];
    stim_t        stim_q[$];
    logic [7:0]   mem [logic [31:0]];

    int          n_checks  = 0;
    int          n_fail    = 0;
    int          cyc       = 0;
    int          exp_dones = 0;
    int          dut_dones = 0;
    logic [31:0] prev_rd   = 32'h0;

    mem_byte_bridge #(.ADDR_W(32), .TIMEOUT(T)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .MemW      (MemW),
        .memSelect (memSelect),
        .Adr       (Adr),
        .WriteData (WriteData),
        .ReadData  (ReadData),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus_req   (bus_req),
        .bus_we    (bus_we),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rdata (bus_rdata),
        .bus_ack   (bus_ack)
    );

    // Clock and reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Model helpers
    function automatic int nbytes(input logic [1:0] sz);
        if (sz == 2'd0) return 1;
        if (sz == 2'd1) return 2;
        if (sz == 2'd2) return 4;
        return 0;
    endfunction

    function automatic logic illegal(input logic [1:0] sz, input logic [1:0] lo);
        if (sz == 2'd3) return 1'b1;
        if (sz == 2'd1 && lo[0]) return 1'b1;
        if (sz == 2'd2 && lo != 2'd0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] extend(input logic [31:0] v, input int n, input logic s);
        logic [31:0] r;
        r = v;
        if (s && n < 4 && v[8*n-1]) r = r | (32'hFFFF_FFFF << (8*n));
        return r;
    endfunction

    function automatic logic [7:0] mem_rd(input logic [31:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    function automatic stim_t rand_stim();
        stim_t s;
        s.rst   = 1'b0;
        s.start = 1'($urandom_range(0, 1));
        s.memw  = 1'($urandom_range(0, 1));
        s.sel   = 3'($urandom_range(0, 7));
        s.adr   = $urandom;
        s.wdata = $urandom;
        s.ack   = 1'($urandom_range(0, 1));
        s.rdata = 8'($urandom);
        return s;
    endfunction

    function automatic out_t idle_exp();
        out_t e;
        e       = '0;
        e.chk   = 1'b1;
        e.rdata = prev_rd;
        return e;
    endfunction

    task automatic push(input stim_t s, input out_t e);
        stim_q.push_back(s);
        exp_q.push_back(W'(e));
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%h expected=%h", name, cyc, got, want);
        end
    endtask

    task automatic add_gap();
        stim_t s;
        int g;
        g = $urandom_range(0, 2);
        for (int i = 0; i < g; i++) begin
            s = rand_stim();
            s.start = 1'b0;
            push(s, idle_exp());
        end
    endtask

    // Driver task: schedule one request with per-byte ack delays.
    task automatic add_txn(input logic memw, input logic [2:0] sel, input logic [31:0] adr,
                           input logic [31:0] wdata, input int dl[4],
                           output int done_cyc, output logic [31:0] fin_rd, output logic fin_err);
        int          n;
        int          cn;
        logic        ill;
        logic        tmo;
        logic [31:0] val;
        logic [7:0]  b;
        stim_t       s;
        out_t        e;
        n   = nbytes(sel[1:0]);
        ill = illegal(sel[1:0], adr[1:0]);
        tmo = 1'b0;
        val = 32'h0;
        s = rand_stim();
        s.start = 1'b1;
        s.memw  = memw;
        s.sel   = sel;
        s.adr   = adr;
        s.wdata = wdata;
        push(s, idle_exp());
        cn = 1;
        if (!ill) begin
            for (int i = 0; i < n && !tmo; i++) begin
                for (int k = 0; k <= dl[i] && k < T; k++) begin
                    s = rand_stim();
                    e = idle_exp();
                    e.busy   = 1'b1;
                    e.req    = 1'b1;
                    e.we     = memw;
                    e.addr   = adr + 32'(i);
                    e.wdata  = wdata[8*i +: 8];
                    e.chk_wd = memw;
                    s.ack    = (k == dl[i]);
                    if (s.ack) begin
                        if (memw) begin
                            mem[adr + 32'(i)] = wdata[8*i +: 8];
                        end else begin
                            b = mem_rd(adr + 32'(i));
                            s.rdata = b;
                            val = val | (32'(b) << (8*i));
                        end
                    end
                    push(s, e);
                    cn++;
                end
                if (dl[i] >= T) tmo = 1'b1;
            end
        end
        fin_err = ill | tmo;
        fin_rd  = prev_rd;
        if (!fin_err && !memw) fin_rd = extend(val, n, sel[2]);
        s = rand_stim();
        e = idle_exp();
        e.done  = 1'b1;
        e.err   = fin_err;
        e.rdata = fin_rd;
        push(s, e);
        done_cyc = cn;
        prev_rd  = fin_rd;
        exp_dones++;
        add_gap();
    endtask

    // Driver task: word load at 0x180 with reset asserted while byte 2 is on the bus.
    task automatic add_reset_abort();
        stim_t s;
        out_t  e;
        s = rand_stim();
        s.start = 1'b1;
        s.memw  = 1'b0;
        s.sel   = 3'b010;
        s.adr   = 32'h180;
        push(s, idle_exp());
        for (int i = 0; i < 3; i++) begin
            s = rand_stim();
            s.ack   = 1'b1;
            s.rdata = mem_rd(32'h180 + 32'(i));
            if (i == 2) s.rst = 1'b1;
            e = idle_exp();
            e.busy = 1'b1;
            e.req  = 1'b1;
            e.we   = 1'b0;
            e.addr = 32'h180 + 32'(i);
            push(s, e);
        end
        prev_rd = 32'h0;
        s = rand_stim();
        s.start = 1'b0;
        e = idle_exp();
        e.full = 1'b1;
        push(s, e);
        add_gap();
    endtask

    task automatic build();
        stim_t       s;
        out_t        e;
        int          dl[4];
        int          dc;
        int          n;
        logic [31:0] rd;
        logic        er;
        logic        memw;
        logic [2:0]  sel;
        logic [31:0] adr;

        s = rand_stim();
        s.rst = 1'b1;
        s.start = 1'b0;
        e = '0;
        push(s, e);
        s = rand_stim();
        s.start = 1'b0;
        e = idle_exp();
        e.full = 1'b1;
        push(s, e);

        mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
        dl = '{0, 0, 0, 0};
        add_txn(1'b0, 3'b010, 32'h100, $urandom, dl, dc, rd, er);
        check("pin_word_done_cycle", 32'(dc), 32'd5);
        check("pin_word_rdata", rd, 32'h4433_2211);
        check("pin_word_err", 32'(er), 32'd0);

        mem[32'h203] = 8'h80;
        add_txn(1'b0, 3'b100, 32'h203, $urandom, dl, dc, rd, er);
        check("pin_sbyte_done_cycle", 32'(dc), 32'd2);
        check("pin_sbyte_rdata", rd, 32'hFFFF_FF80);
        add_txn(1'b0, 3'b000, 32'h203, $urandom, dl, dc, rd, er);
        check("pin_ubyte_rdata", rd, 32'h0000_0080);

        dl = '{3, 3, 0, 0};
        add_txn(1'b1, 3'b001, 32'h40, 32'hDEAD_BEEF, dl, dc, rd, er);
        check("pin_hstore_done_cycle", 32'(dc), 32'd9);
        check("pin_hstore_rdata_kept", rd, 32'h0000_0080);
        check("pin_hstore_mem40", 32'(mem[32'h40]), 32'hEF);
        check("pin_hstore_mem41", 32'(mem[32'h41]), 32'hBE);

        dl = '{0, 0, 0, 0};
        add_txn(1'b0, 3'b101, 32'h40, $urandom, dl, dc, rd, er);
        check("pin_shalf_rdata", rd, 32'hFFFF_BEEF);

        add_txn(1'b0, 3'b010, 32'h102, $urandom, dl, dc, rd, er);
        check("pin_misalign_done_cycle", 32'(dc), 32'd1);
        check("pin_misalign_err", 32'(er), 32'd1);
        add_txn(1'b0, 3'b011, 32'h0, $urandom, dl, dc, rd, er);
        check("pin_reserved_err", 32'(er), 32'd1);

        dl = '{9, 0, 0, 0};
        add_txn(1'b0, 3'b010, 32'h104, $urandom, dl, dc, rd, er);
        check("pin_timeout_done_cycle", 32'(dc), 32'd5);
        check("pin_timeout_err", 32'(er), 32'd1);
        check("pin_timeout_rdata_kept", rd, 32'hFFFF_BEEF);

        add_reset_abort();
        dl = '{1, 0, 2, 0};
        add_txn(1'b0, 3'b010, 32'h100, $urandom, dl, dc, rd, er);
        check("pin_after_reset_rdata", rd, 32'h4433_2211);

        for (int t = 0; t < 150; t++) begin
            memw = 1'($urandom_range(0, 1));
            sel  = 3'($urandom_range(0, 7));
            n    = nbytes(sel[1:0]);
            adr  = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0 && n > 0) adr = adr & ~32'(n - 1);
            for (int i = 0; i < 4; i++) begin
                dl[i] = ($urandom_range(0, 9) == 0) ? int'($urandom_range(4, 6)) : int'($urandom_range(0, 3));
            end
            add_txn(memw, sel, adr, $urandom, dl, dc, rd, er);
        end
    endtask

    task automatic run_drive();
        stim_t s;
        @(posedge clk);
        #1;
        while (stim_q.size() > 0) begin
            s = stim_q.pop_front();
            reset     = s.rst;
            start     = s.start;
            MemW      = s.memw;
            memSelect = s.sel;
            Adr       = s.adr;
            WriteData = s.wdata;
            bus_ack   = s.ack;
            bus_rdata = s.rdata;
            @(posedge clk);
            #1;
        end
    endtask

    // Scoreboard: compare every cycle against the expected queue
    task automatic run_compare();
        out_t e;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            if (done === 1'b1) dut_dones++;
            if (e.chk) begin
                check("busy", 32'(busy), 32'(e.busy));
                check("done", 32'(done), 32'(e.done));
                check("err", 32'(err), 32'(e.err));
                check("bus_req", 32'(bus_req), 32'(e.req));
                check("ReadData", ReadData, e.rdata);
                if (e.req || e.full) begin
                    check("bus_we", 32'(bus_we), 32'(e.we));
                    check("bus_addr", bus_addr, e.addr);
                end
                if (e.chk_wd || e.full) begin
                    check("bus_wdata", 32'(bus_wdata), 32'(e.wdata));
                end
            end
            cyc++;
        end
    endtask

    // Main sequence and final report
    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        MemW      = 1'b0;
        memSelect = 3'b000;
        Adr       = 32'h0;
        WriteData = 32'h0;
        bus_ack   = 1'b0;
        bus_rdata = 8'h0;
        build();
        fork
            run_drive();
            run_compare();
        join
        check("done_pulse_count", 32'(dut_dones), 32'(exp_dones));
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
